// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The master side drives Start and the operands; the slave side (the divider)
// returns Busy/Done and the registered results.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             Start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Div_Zero;
    logic             Overflow;

    modport master (
        output Start, Dividend, Divisor,
        input  Busy, Done, Quotient, Remainder, Div_Zero, Overflow
    );

    modport slave (
        input  Start, Dividend, Divisor,
        output Busy, Done, Quotient, Remainder, Div_Zero, Overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH iterations.
// Start/Busy/Done handshake; results are held until the next completion.
// Optional macro SIGNED_DIV_EN: two's-complement operands, with the iteration
// run on magnitudes and signs fixed up on entry to DONE (truncation toward zero).
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DZERO = 2'd2,   // one-cycle wait so a zero-divisor op completes one edge after accept
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    // The partial remainder always stays below the divisor, so WIDTH bits hold it;
    // the extra bit only exists in the trial subtraction.
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_q;
    logic             ovf_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quot_fin;
    logic [WIDTH-1:0] rem_fin;
    logic             ovf_fin;

`ifdef SIGNED_DIV_EN
    logic qneg_q;       // quotient must be negated at the end
    logic rneg_q;       // remainder must be negated (dividend was negative)
    logic ovf_pend_q;   // most-negative / -1 detected at accept
    logic dvd_neg;
    logic dvs_neg;
    logic ovf_case;
`endif

    // Operand conditioning at accept and one restoring-division step per cycle
    always_comb begin
`ifdef SIGNED_DIV_EN
        dvd_neg  = bus.Dividend[WIDTH-1];
        dvs_neg  = bus.Divisor[WIDTH-1];
        dvd_mag  = dvd_neg ? (~bus.Dividend + WIDTH'(1)) : bus.Dividend;
        dvs_mag  = dvs_neg ? (~bus.Divisor + WIDTH'(1)) : bus.Divisor;
        ovf_case = (bus.Dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.Divisor == '1);
`else
        dvd_mag  = bus.Dividend;
        dvs_mag  = bus.Divisor;
`endif
        r_shift = {r_q, q_q[WIDTH-1]};
        trial   = r_shift - {1'b0, dvs_q};
        r_d     = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        q_d     = {q_q[WIDTH-2:0], ~trial[WIDTH]};
`ifdef SIGNED_DIV_EN
        quot_fin = qneg_q ? (~q_d + WIDTH'(1)) : q_d;
        rem_fin  = rneg_q ? (~r_d + WIDTH'(1)) : r_d;
        ovf_fin  = ovf_pend_q;
`else
        quot_fin = q_d;
        rem_fin  = r_d;
        ovf_fin  = 1'b0;
`endif
    end

    // Control FSM with registered handshake outputs and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (bus.Start) begin
                        if (bus.Divisor == '0) begin
                            // Keep the raw dividend: it becomes the remainder
                            q_q     <= bus.Dividend;
                            state_q <= DZERO;
                        end else begin
                            r_q     <= '0;
                            q_q     <= dvd_mag;
                            dvs_q   <= dvs_mag;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
`ifdef SIGNED_DIV_EN
                            qneg_q     <= dvd_neg ^ dvs_neg;
                            rneg_q     <= dvd_neg;
                            ovf_pend_q <= ovf_case;
`endif
                        end
                    end
                end
                DZERO: begin
                    quot_q  <= '1;
                    rem_q   <= q_q;
                    dz_q    <= 1'b1;
                    ovf_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        quot_q  <= quot_fin;
                        rem_q   <= rem_fin;
                        dz_q    <= 1'b0;
                        ovf_q   <= ovf_fin;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Quotient  = quot_q;
    assign bus.Remainder = rem_q;
    assign bus.Div_Zero  = dz_q;
    assign bus.Overflow  = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=4): expected results come from a
// behavioural model pushed to a scoreboard queue at Start and popped on Done.
module tb_seq_divider;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.ovf = 1'b0;
        end else begin
`ifdef SIGNED_DIV_EN
            e.q   = W'(sa / sbv);
            e.r   = W'(sa % sbv);
            e.ovf = (sa == -(1 << (W - 1))) && (sbv == -1);
`else
            e.q   = a / b;
            e.r   = a % b;
            e.ovf = 1'b0;
            if (sa == sbv) e.ovf = 1'b0;
`endif
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the first sample after the accepting edge; waits for Done
    task automatic wait_done(input int exp_lat, input int exp_busy);
        int   lat;
        int   busy_cnt;
        exp_t e;
        lat = 0;
        busy_cnt = 0;
        while (bus.Done !== 1'b1 && lat < 20) begin
            if (bus.Busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check("done_latency", lat, exp_lat);
        check("busy_cycles", busy_cnt, exp_busy);
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("op done: Q=%0h R=%0h DZ=%0b OVF=%0b (exp Q=%0h R=%0h DZ=%0b OVF=%0b)",
                     bus.Quotient, bus.Remainder, bus.Div_Zero, bus.Overflow, e.q, e.r, e.dz, e.ovf);
            check("quotient", bus.Quotient, e.q);
            check("remainder", bus.Remainder, e.r);
            check("div_zero", bus.Div_Zero, e.dz);
            check("overflow", bus.Overflow, e.ovf);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.Start = 1'b1; bus.Dividend = a; bus.Divisor = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.Start = 1'b0;
        if (b == '0) wait_done(1, 0);
        else         wait_done(W, W);
        @(negedge clk);
        check("done_pulse_width", bus.Done, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.Start = 1'b0; bus.Dividend = '0; bus.Divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.Busy, 1'b0);
        check("rst_done", bus.Done, 1'b0);
        check("rst_q", bus.Quotient, '0);
        check("rst_r", bus.Remainder, '0);
        check("rst_dz", bus.Div_Zero, 1'b0);
        check("rst_ovf", bus.Overflow, 1'b0);
        rst = 1'b0;

        // Basic ops and boundaries
        run_op(4'd13, 4'd3);
        run_op(4'd7, 4'd0);
        run_op(4'd15, 4'd1);
        run_op(4'd2, 4'd5);
        run_op(4'd0, 4'd9);
        run_op(4'd15, 4'd15);
        run_op(4'd11, 4'd4);

        // Start during CALC ignored; Start held into DONE accepted
        @(negedge clk);
        bus.Start = 1'b1; bus.Dividend = 4'd13; bus.Divisor = 4'd3;
        sb.push_back(model(4'd13, 4'd3));
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        bus.Start = 1'b1; bus.Dividend = 4'd9; bus.Divisor = 4'd2;
        wait_done(W - 1, W - 1);
        sb.push_back(model(4'd9, 4'd2));
        @(negedge clk);
        bus.Start = 1'b0;
        check("b2b_done_drop", bus.Done, 1'b0);
        wait_done(W, W);
        @(negedge clk);
        check("done_pulse_width", bus.Done, 1'b0);

        // Reset in the middle of CALC aborts the op
        @(negedge clk);
        bus.Start = 1'b1; bus.Dividend = 4'd13; bus.Divisor = 4'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.Busy, 1'b0);
        check("abort_q", bus.Quotient, '0);
        check("abort_r", bus.Remainder, '0);
        check("abort_dz", bus.Div_Zero, 1'b0);
        begin
            int done_seen;
            done_seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus.Done === 1'b1) done_seen++;
            end
            check("abort_no_done", done_seen, 0);
        end
        run_op(4'd9, 4'd2);

`ifdef SIGNED_DIV_EN
        run_op(4'b1001, 4'd2);
        run_op(4'd7, 4'b1110);
        run_op(4'b1000, 4'b1111);
        run_op(4'b1010, 4'b1101);
        run_op(4'b1011, 4'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse-operation companion to the 4-bit adder/subtractor datapath.
- Divides Dividend by Divisor one quotient bit per clock, using a WIDTH+1-bit trial subtraction.
- Returns Quotient and Remainder with a Start/Busy/Done handshake.
- Sits beside the combinational add/sub unit in the ALU path.

Parameters:
- WIDTH, 4, operand/result width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when Busy=0.
- Dividend  input  WIDTH  numerator; latched on accepted Start.
- Divisor  input  WIDTH  denominator; latched on accepted Start.
- Busy  output  1  high while iterating (CALC state).
- Done  output  1  one-cycle completion pulse.
- Quotient  output  WIDTH  result quotient.
- Remainder  output  WIDTH  result remainder.
- Div_Zero  output  1  last operation had Divisor=0.
- Overflow  output  1  last result not representable (signed mode only; otherwise 0).

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE. Busy, Done, Quotient, Remainder, Div_Zero and Overflow all 0. Internal registers cleared.
- Reset mid-CALC: abort; no Done for the aborted op.
- States:
  - IDLE: Busy=0.
  - CALC: Busy=1, iteration counter 0..WIDTH-1.
  - DONE: Busy=0, Done=1, lasts exactly one cycle, then IDLE.
- Start acceptance: accepted on an edge where Start=1 and state is IDLE or DONE. Start during CALC is ignored; no queuing.
- Accept, Divisor≠0:
  - Latch operands; R=0 (WIDTH+1 bits); Q=Dividend; counter=0; go to CALC.
- CALC, each edge:
  - {R,Q} shifted left 1.
  - trial = R_shifted − {0,Divisor}.
  - If trial MSB=0: R=trial and Q[0]=1; else R is kept and Q[0]=0.
  - counter+1.
  - On the iteration where counter=WIDTH-1: go to DONE and register Quotient=Q, Remainder=R[WIDTH-1:0], Div_Zero=0, Overflow=0.
- Latency: Start sampled at edge k → Done high in the cycle following edge k+WIDTH. Busy high for exactly WIDTH cycles.
- Accept, Divisor=0:
  - No iteration; go to DONE at edge k+1.
  - Quotient=all ones, Remainder=Dividend, Div_Zero=1, Overflow=0.
- Result holding: Quotient, Remainder, Div_Zero and Overflow are updated only on entry to DONE and hold until the next completion.
- Back-to-back: Start in the DONE cycle begins a new op at the next edge; Done drops normally.
- Arithmetic: unsigned, truncating; Remainder < Divisor always.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement.
  - At accept, magnitudes are latched and the result sign (Dividend sign XOR Divisor sign) and the Dividend sign are recorded.
  - Iteration runs on magnitudes; same latency.
  - On entry to DONE, Quotient is negated if the signs differ. Remainder is negated if the Dividend was negative (truncation toward zero; Remainder takes the sign of the Dividend).
  - Most-negative / −1 (e.g. −8/−1 at WIDTH=4): Quotient=most-negative pattern, Remainder=0, Overflow=1.
  - Divide by zero: same as unsigned mode.
- Undefined: unsigned only; Overflow tied to 0; no sign logic synthesized.

Test Plan:
- Dividend=13, Divisor=3, Start pulse at edge k → Busy high 4 cycles; Done after edge k+4 for exactly 1 cycle; Quotient=4, Remainder=1, Div_Zero=0.
- Dividend=7, Divisor=0 → Done after edge k+1; Busy never high; Quotient=15, Remainder=7, Div_Zero=1.
- Boundaries: 15/1 → Q=15, R=0; 2/5 → Q=0, R=2; 0/9 → Q=0, R=0; 15/15 → Q=1, R=0.
- Start 13/3, then Start=1 with 9/2 at cycle 2 of CALC → second request ignored; result Q=4, R=1. A Start with 9/2 held during the DONE cycle → accepted; next result Q=4, R=1 after 4 more cycles.
- rst asserted in cycle 2 of CALC for 13/3 → all outputs 0 next cycle; no Done; a subsequent 9/2 gives Q=4, R=1.
- With SIGNED_DIV_EN: −7/2 → Q=4'b1101 (−3), R=4'b1111 (−1); 7/−2 → Q=−3, R=1; −8/−1 → Q=4'b1000, R=0, Overflow=1.
